// File: rtl/seq_pkg.sv
// seq_pkg: shared state encodings and parameter defaults for the sequence generator
package seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  // Detector states: A = no 1 seen, B = one 1, C = two or more consecutive 1s
  typedef enum logic [1:0] {A, B, C} det_t;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W = $clog2(DEF_DATA_W + 1);
endpackage

// File: rtl/seq_exp_model.sv
// seq_exp_model: golden model of the Moore "two or more consecutive 1s" detector
// Ports: clk, reset (async, active-high), w (serial input), exp_z (predicted detector z)
import seq_pkg::*;
module seq_exp_model (
  input  logic clk,
  input  logic reset,
  input  logic w,
  output logic exp_z
);
  det_t r;
  // Run counter saturating at C, cleared by any 0 on w
  always_ff @(posedge clk or posedge reset)
    if (reset) r <= A;
    else r <= !w ? A : r == A ? B : C;
  assign exp_z = r == C;
endmodule

// File: rtl/sequence_generator.sv
// sequence_generator: serial pattern transmitter with predicted detector output
// Ports: clk, reset (async, active-high); start_valid/start_ready handshake with
// pattern, len, repeat_n; serial w/w_valid; busy; done pulse; exp_z prediction
import seq_pkg::*;
module sequence_generator #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] pattern,
  input  logic [LEN_W-1:0]  len,
  input  logic [3:0]        repeat_n,
  output logic              w,
  output logic              w_valid,
  output logic              busy,
  output logic              done,
  output logic              exp_z
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);
  state_t state, state_n;
  logic [DATA_W-1:0] shadow, sr, aligned;
  logic [LEN_W-1:0] slen, cnt, lenc;
  logic [3:0] rep;
  logic [GW-1:0] gcnt;
  logic acc, last_bit, frame_end, reload;
  // Pattern is stored MSB-aligned so the next bit is always the top bit;
  // cnt counts the bits still to come after the one currently on w.
  always_comb begin
    lenc = len > MAX_LEN ? MAX_LEN : len;
    aligned = pattern << (MAX_LEN - lenc);
    acc = start_valid && state == IDLE;
    last_bit = state == SHIFT && cnt == '0;
    frame_end = (last_bit && GAP_CYCLES == 0) || (state == GAP && gcnt == '0);
    reload = frame_end && rep != '0;
    state_n = acc && lenc != '0 ? SHIFT : reload ? SHIFT : frame_end ? IDLE : last_bit ? GAP : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      shadow <= '0;
      sr <= '0;
      slen <= '0;
      cnt <= '0;
      rep <= '0;
      gcnt <= '0;
      w <= 1'b0;
      w_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= (acc && lenc == '0) || (frame_end && !reload);
      if (acc) begin
        shadow <= aligned;
        slen <= lenc;
        rep <= repeat_n;
        sr <= aligned << 1;
        cnt <= lenc - LEN_W'(1);
        w <= lenc != '0 && aligned[DATA_W-1];
        w_valid <= lenc != '0;
      end else if (reload) begin
        rep <= rep - 4'd1;
        sr <= shadow << 1;
        cnt <= slen - LEN_W'(1);
        w <= shadow[DATA_W-1];
        w_valid <= 1'b1;
      end else if (state == SHIFT && cnt != '0) begin
        w <= sr[DATA_W-1];
        sr <= sr << 1;
        cnt <= cnt - LEN_W'(1);
      end else if (last_bit || frame_end) begin
        w <= 1'b0;
        w_valid <= 1'b0;
        gcnt <= GW'(GAP_CYCLES - 1);
      end else if (state == GAP)
        gcnt <= gcnt - GW'(1);
    end
  assign start_ready = state == IDLE;
  assign busy = state != IDLE;
  seq_exp_model u_model (.clk(clk), .reset(reset), .w(w), .exp_z(exp_z));
endmodule
